tx_ipv4: RTL and testbench

TX_IPV4 -- requirements
Module: tx_ipv4

---
 rtl/tx_ipv4.sv | 195 +++++++++++++++++++
 tb/tb_tx_ipv4.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ipv4.sv
// IPv4 transmit framer: latches one request, then streams the 20-byte header and the payload to the MAC.
// Optional macro TX_IPV4_CHECKSUM_EN adds the CSUM/FOLD states; without it the checksum is sent as 00 00.
module tx_ipv4 #(
  parameter int          OCT        = 8,
  parameter logic [7:0]  TTL        = 8'h40,
  parameter logic [15:0] FLAGS_FRAG = 16'h4000
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic [31:0]    tx_dst_ip,
  input  logic [7:0]     tx_protocol,
  input  logic [15:0]    tx_len,
  input  logic           tx_start,
  output logic           tx_busy,
  input  logic [OCT-1:0] tx_data,
  output logic           tx_data_req,
  input  logic           tx_ready,
  output logic           tx_payload_ipv4,
  output logic [OCT-1:0] tx_payload,
  output logic           tx_last,
  output logic           tx_ipv4_done
);

  typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, DATA, DONE} state_t;

  state_t        state_reg;
  logic [31:0]   src_reg;
  logic [31:0]   dst_reg;
  logic [7:0]    proto_reg;
  logic [15:0]   len_reg;
  logic [15:0]   id_reg;
  logic [15:0]   cnt_reg;
  logic          last_loaded_reg;
  logic [15:0]   total_len;
  logic [OCT-1:0] hdr_byte [20];
  logic          load_ok;
  logic          xfer;

`ifdef TX_IPV4_CHECKSUM_EN
  logic [19:0]   sum_reg;
  logic [15:0]   csum_reg;
  logic [15:0]   hdr_half [10];
  logic [16:0]   fold1;
  logic [15:0]   fold2;
`endif

  assign total_len = len_reg + 16'd20;

  always_comb begin
    hdr_byte[0]  = 8'h45;
    hdr_byte[1]  = 8'h00;
    hdr_byte[2]  = total_len[15:8];
    hdr_byte[3]  = total_len[7:0];
    hdr_byte[4]  = id_reg[15:8];
    hdr_byte[5]  = id_reg[7:0];
    hdr_byte[6]  = FLAGS_FRAG[15:8];
    hdr_byte[7]  = FLAGS_FRAG[7:0];
    hdr_byte[8]  = TTL;
    hdr_byte[9]  = proto_reg;
`ifdef TX_IPV4_CHECKSUM_EN
    hdr_byte[10] = csum_reg[15:8];
    hdr_byte[11] = csum_reg[7:0];
`else
    hdr_byte[10] = 8'h00;
    hdr_byte[11] = 8'h00;
`endif
    hdr_byte[12] = src_reg[31:24];
    hdr_byte[13] = src_reg[23:16];
    hdr_byte[14] = src_reg[15:8];
    hdr_byte[15] = src_reg[7:0];
    hdr_byte[16] = dst_reg[31:24];
    hdr_byte[17] = dst_reg[23:16];
    hdr_byte[18] = dst_reg[15:8];
    hdr_byte[19] = dst_reg[7:0];
  end

`ifdef TX_IPV4_CHECKSUM_EN
  // Halfword 5 is the checksum field itself, summed as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_half
      if (gi == 5) begin : g_zero
        assign hdr_half[gi] = 16'h0000;
      end else begin : g_pair
        assign hdr_half[gi] = {hdr_byte[2*gi], hdr_byte[2*gi+1]};
      end
    end
  endgenerate

  assign fold1 = {1'b0, sum_reg[15:0]} + {13'h0000, sum_reg[19:16]};
  assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};
`endif

  // Output register may take a new byte when empty or when its byte is being accepted.
  assign load_ok     = !tx_payload_ipv4 || tx_ready;
  assign xfer        = tx_payload_ipv4 && tx_ready;
  assign tx_data_req = (state_reg == DATA) && !last_loaded_reg && load_ok;

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_reg       <= IDLE;
      src_reg         <= '0;
      dst_reg         <= '0;
      proto_reg       <= '0;
      len_reg         <= '0;
      id_reg          <= '0;
      cnt_reg         <= '0;
      last_loaded_reg <= 1'b0;
      tx_busy         <= 1'b0;
      tx_payload_ipv4 <= 1'b0;
      tx_payload      <= '0;
      tx_last         <= 1'b0;
      tx_ipv4_done    <= 1'b0;
`ifdef TX_IPV4_CHECKSUM_EN
      sum_reg         <= '0;
      csum_reg        <= '0;
`endif
    end else begin
      tx_ipv4_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_start) begin
            src_reg         <= ip_addr;
            dst_reg         <= tx_dst_ip;
            proto_reg       <= tx_protocol;
            len_reg         <= tx_len;
            cnt_reg         <= '0;
            last_loaded_reg <= 1'b0;
            tx_busy         <= 1'b1;
`ifdef TX_IPV4_CHECKSUM_EN
            sum_reg         <= '0;
            state_reg       <= CSUM;
`else
            state_reg       <= HDR;
`endif
          end
        end
`ifdef TX_IPV4_CHECKSUM_EN
        CSUM: begin
          sum_reg <= sum_reg + {4'h0, hdr_half[cnt_reg[3:0]]};
          if (cnt_reg == 16'd9) begin
            cnt_reg   <= '0;
            state_reg <= FOLD;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        FOLD: begin
          csum_reg  <= ~fold2;
          state_reg <= HDR;
        end
`endif
        HDR, DATA: begin
          if (last_loaded_reg) begin
            if (xfer) begin
              tx_payload_ipv4 <= 1'b0;
              tx_last         <= 1'b0;
              tx_busy         <= 1'b0;
              tx_ipv4_done    <= 1'b1;
              state_reg       <= DONE;
            end
          end else if (load_ok) begin
            tx_payload_ipv4 <= 1'b1;
            cnt_reg         <= cnt_reg + 16'd1;
            if (state_reg == HDR) begin
              tx_payload <= hdr_byte[cnt_reg[4:0]];
              if (cnt_reg == 16'd19) begin
                cnt_reg <= '0;
                if (len_reg == 16'd0) begin
                  tx_last         <= 1'b1;
                  last_loaded_reg <= 1'b1;
                end else begin
                  state_reg <= DATA;
                end
              end
            end else begin
              tx_payload <= tx_data;
              if (cnt_reg == len_reg - 16'd1) begin
                tx_last         <= 1'b1;
                last_loaded_reg <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          id_reg    <= id_reg + 16'd1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ipv4.sv
// Directed/randomized bench for tx_ipv4: a byte-level reference model of the datagram checked against the stream.
module tb_tx_ipv4;

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ip_addr = '0;
  logic [31:0] tx_dst_ip = '0;
  logic [7:0]  tx_protocol = '0;
  logic [15:0] tx_len = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_req;
  logic        tx_ready = 1'b1;
  logic        tx_payload_ipv4;
  logic [7:0]  tx_payload;
  logic        tx_last;
  logic        tx_ipv4_done;

`ifdef TX_IPV4_CHECKSUM_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 1;
`endif

  tx_ipv4 dut (
    .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr), .tx_dst_ip(tx_dst_ip),
    .tx_protocol(tx_protocol), .tx_len(tx_len), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_data_req(tx_data_req), .tx_ready(tx_ready),
    .tx_payload_ipv4(tx_payload_ipv4), .tx_payload(tx_payload), .tx_last(tx_last),
    .tx_ipv4_done(tx_ipv4_done)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  // Upstream FWFT source: one pop per cycle in which tx_data_req was seen high.
  logic [7:0]  src_mem [4096];
  logic [31:0] src_idx = '0;
  logic        req_flag = 1'b0;
  assign tx_data = src_mem[src_idx[11:0]];
  always @(posedge RX_CLK) if (req_flag) src_idx <= src_idx + 1;

  logic [7:0] got_q[$];
  logic       last_q[$];
  int         done_cnt = 0;
  int         req_cnt = 0;
  int         rise_cyc = -1;
  logic       prev_v = 1'b0;

  always @(negedge RX_CLK) begin
    if (!rst) begin
      if (tx_payload_ipv4 && tx_ready) begin
        got_q.push_back(tx_payload);
        last_q.push_back(tx_last);
      end
      if (tx_ipv4_done) done_cnt++;
      if (tx_data_req) req_cnt++;
      if (tx_payload_ipv4 && !prev_v) rise_cyc = cyc;
    end
    req_flag <= !rst && tx_data_req;
    prev_v = tx_payload_ipv4;
  end

  logic [7:0]  exp_q[$];
  logic [15:0] exp_id = 16'h0000;
  int          fb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference datagram from the header rules; checksum folded until no carry remains.
  task automatic build_expected(input logic [31:0] src, input logic [31:0] dst,
                                input logic [7:0] proto, input logic [15:0] len,
                                input logic [31:0] pbase);
    logic [15:0] tot;
    logic [15:0] cs;
    logic [15:0] w [10];
    int unsigned s;
    tot = len + 16'd20;
    w[0] = 16'h4500; w[1] = tot; w[2] = exp_id; w[3] = 16'h4000;
    w[4] = {8'h40, proto}; w[5] = 16'h0000;
    w[6] = src[31:16]; w[7] = src[15:0]; w[8] = dst[31:16]; w[9] = dst[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`ifdef TX_IPV4_CHECKSUM_EN
    cs = ~s[15:0];
`else
    cs = 16'h0000;
`endif
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        exp_q.push_back(cs[15:8]);
        exp_q.push_back(cs[7:0]);
      end else begin
        exp_q.push_back(w[i][15:8]);
        exp_q.push_back(w[i][7:0]);
      end
    end
    for (int i = 0; i < int'(len); i++) exp_q.push_back(src_mem[12'(pbase + i)]);
  endtask

  task automatic send_frame(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input logic [7:0] proto, input logic [15:0] len,
                            input bit rnd_ready, input bit poke_busy, input bit poke_done);
    int d0, r0, st, nlast, gsize;
    bit ok;
    logic [31:0] pbase;
    logic [31:0] obs;
    fb = got_q.size();
    d0 = done_cnt;
    r0 = req_cnt;
    pbase = src_idx;
    for (int i = 0; i < int'(len); i++) src_mem[12'(pbase + i)] = 8'($urandom);
    build_expected(src, dst, proto, len, pbase);
    ip_addr = src; tx_dst_ip = dst; tx_protocol = proto; tx_len = len;
    tx_start = 1'b1;
    st = cyc + 1;
    @(posedge RX_CLK); #1;
    tx_start = 1'b0;
    ip_addr = $urandom; tx_dst_ip = $urandom; tx_protocol = 8'($urandom); tx_len = 16'($urandom);
    check({name, " busy_after_start"}, tx_busy, 1);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (tx_ipv4_done) begin
        ok = 1'b1;
        break;
      end
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_start = poke_busy && (c == 4 || c == 25);
      @(posedge RX_CLK); #1;
    end
    tx_start = 1'b0;
    tx_ready = 1'b1;
    check({name, " done_seen"}, ok, 1);
    check({name, " busy_low_at_done"}, tx_busy, 0);
    if (poke_done) begin
      tx_start = 1'b1;
      @(posedge RX_CLK); #1;
      tx_start = 1'b0;
    end
    repeat (20) begin
      @(posedge RX_CLK); #1;
    end
    gsize = got_q.size();
    check({name, " byte_count"}, gsize - fb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (fb + i < gsize) ? {24'h0, got_q[fb + i]} : 32'hDEAD_BEEF;
      check($sformatf("%s byte%0d", name, i), obs, {24'h0, exp_q[i]});
    end
    nlast = 0;
    for (int i = fb; i < gsize; i++) nlast += int'(last_q[i]);
    check({name, " last_count"}, nlast, 1);
    check({name, " last_on_final"}, (gsize > fb) ? last_q[gsize - 1] : 1'b0, 1);
    check({name, " done_pulses"}, done_cnt - d0, 1);
    check({name, " req_pulses"}, req_cnt - r0, len);
    check({name, " first_byte_latency"}, rise_cyc - st, LAT);
    check({name, " idle_after"}, tx_busy, 0);
    exp_id = exp_id + 16'd1;
    $display("frame %s: len=%0d bytes=%0d id=%0h", name, len, gsize - fb, exp_id - 16'd1);
  endtask

  initial begin
    logic [15:0] ff;
    int d0;
    ff = 16'h4000;
    repeat (3) @(posedge RX_CLK);
    #1;
    check("rst busy", tx_busy, 0);
    check("rst valid", tx_payload_ipv4, 0);
    check("rst last", tx_last, 0);
    check("rst done", tx_ipv4_done, 0);
    check("rst req", tx_data_req, 0);
    check("rst payload", tx_payload, 0);
    rst = 1'b0;
    @(posedge RX_CLK); #1;

    // Reference datagram with fixed header values
    send_frame("A", 32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95, 1'b0, 1'b0, 1'b0);
    check("A total_len hi", got_q[fb + 2], 8'h00);
    check("A total_len lo", got_q[fb + 3], 8'h73);
`ifdef TX_IPV4_CHECKSUM_EN
    check("A csum", {got_q[fb + 10], got_q[fb + 11]}, 16'hB861);
`else
    check("A csum", {got_q[fb + 10], got_q[fb + 11]}, 16'h0000);
`endif

    send_frame("B_len0", $urandom, $urandom, 8'($urandom), 16'd0, 1'b1, 1'b0, 1'b0);
    check("B id lo", got_q[fb + 5], 8'h01);
    check("B total_len lo", got_q[fb + 3], 8'h14);

    send_frame("C_rand", $urandom, $urandom, 8'($urandom), 16'($urandom_range(1, 60)),
               1'b1, 1'b1, 1'b1);

    // Abort while header byte 7 is on the output
    d0 = done_cnt;
    fb = got_q.size();
    ip_addr = $urandom; tx_dst_ip = $urandom; tx_protocol = 8'h06; tx_len = 16'd10;
    tx_start = 1'b1;
    @(posedge RX_CLK); #1;
    tx_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (got_q.size() - fb >= 7) break;
      @(posedge RX_CLK); #1;
    end
    check("abort at_byte7", got_q.size() - fb, 7);
    check("abort byte7 value", tx_payload, {24'h0, ff[7:0]});
    rst = 1'b1;
    @(posedge RX_CLK); #1;
    check("abort busy", tx_busy, 0);
    check("abort valid", tx_payload_ipv4, 0);
    check("abort last", tx_last, 0);
    check("abort done", tx_ipv4_done, 0);
    check("abort req", tx_data_req, 0);
    check("abort payload", tx_payload, 0);
    rst = 1'b0;
    exp_id = 16'h0000;
    repeat (20) begin
      @(posedge RX_CLK); #1;
    end
    check("abort no_done", done_cnt - d0, 0);
    check("abort idle", tx_busy, 0);
    $display("abort: reset applied during header byte 7");

    send_frame("D_after_rst", 32'hC0A80001, 32'hC0A800C7, 8'h11, 16'd95, 1'b1, 1'b0, 1'b0);
    check("D id", {got_q[fb + 4], got_q[fb + 5]}, 16'h0000);

    send_frame("E_rand", $urandom, $urandom, 8'($urandom), 16'($urandom_range(1, 80)),
               1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
